// File: rtl/meter_display_ctrl.sv
// Parking-meter display: serial binary->BCD (double dabble), 4-digit scan, value-dependent blink.
// Latency: 18 cycles from sample to display; no backpressure, Bin16 is resampled every conversion.
module meter_display_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic [15:0] Bin16,
  output logic [3:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    iter_q, iter_d;
  logic [15:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   samp_q, samp_d;
  logic [15:0]   dig_q, dig_d;
  logic [15:0]   val_q, val_d;
  logic [SW-1:0] dwell_q, dwell_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          fast_on_q, fast_on_d;
  logic          slow_on_q, slow_on_d;
  logic          half_q, half_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [15:0]   clamped;
  logic [15:0]   bcd_adj;
  logic [3:0]    cur_dig;
  logic          scan_tc, blink_tc, blank;

  assign clamped = (Bin16 > 16'd9999) ? 16'd9999 : Bin16;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    samp_d  = samp_q;
    dig_d   = dig_q;
    val_d   = val_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        samp_d  = clamped;
        bin_d   = clamped;
        bcd_d   = '0;
        iter_d  = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        dig_d   = bcd_q;
        val_d   = samp_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slow phase toggles on every second half-tick, tracked by half_q.
  always_comb begin
    scan_tc   = (dwell_q == SW'(SCAN_DIV - 1));
    dwell_d   = scan_tc ? '0 : dwell_q + SW'(1);
    idx_d     = scan_tc ? idx_q + 2'd1 : idx_q;
    blink_tc  = (blink_q == BW'(BLINK_DIV - 1));
    blink_d   = blink_tc ? '0 : blink_q + BW'(1);
    fast_on_d = blink_tc ? ~fast_on_q : fast_on_q;
    half_d    = blink_tc ? ~half_q : half_q;
    slow_on_d = (blink_tc && half_q) ? ~slow_on_q : slow_on_q;
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_dig = dig_q[3:0];
      2'd1:    cur_dig = dig_q[7:4];
      2'd2:    cur_dig = dig_q[11:8];
      default: cur_dig = dig_q[15:12];
    endcase
    blank = ((val_q == 16'd0) && !fast_on_q) ||
            ((val_q != 16'd0) && (val_q < 16'd200) && !slow_on_q);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : seg_code(cur_dig);
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      iter_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      samp_q    <= '0;
      dig_q     <= '0;
      val_q     <= '0;
      dwell_q   <= '0;
      idx_q     <= '0;
      blink_q   <= '0;
      fast_on_q <= 1'b1;
      slow_on_q <= 1'b1;
      half_q    <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      samp_q    <= samp_d;
      dig_q     <= dig_d;
      val_q     <= val_d;
      dwell_q   <= dwell_d;
      idx_q     <= idx_d;
      blink_q   <= blink_d;
      fast_on_q <= fast_on_d;
      slow_on_q <= slow_on_d;
      half_q    <= half_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = 1'b1;

endmodule

// File: tb/tb_meter_display_ctrl.sv
// Bench for meter_display_ctrl: randomized Bin16 sequences scored against an arithmetic display model.
module tb_meter_display_ctrl;

  localparam int SD = 4;
  localparam int BD = 100;

  logic        SYS_CLK;
  logic        RESET_N;
  logic [15:0] Bin16;
  logic [3:0]  An;
  logic [6:0]  Seg;
  logic        Dp;

  meter_display_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .SYS_CLK(SYS_CLK),
    .RESET_N(RESET_N),
    .Bin16  (Bin16),
    .An     (An),
    .Seg    (Seg),
    .Dp     (Dp)
  );

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   running = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int pow10 [4] = '{1, 10, 100, 1000};

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  // cyc = number of rising edges seen since RESET_N was released
  always @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic int clamp(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  // Conversions sample on edges 1, 19, 37, ...; a value written after edge c is
  // first seen by the next sampling edge and reaches the pins 18 edges later.
  function automatic int vis(int c);
    return 18 * ((c + 17) / 18) + 1 + 18;
  endfunction

  // Expected pins after edge k with displayed value v (decimal arithmetic only).
  function automatic exp_t model(int k, int v);
    exp_t e;
    int idx, ht, dig;
    bit fast_on, slow_on, blank;
    idx     = ((k - 1) / SD) % 4;
    ht      = (k - 1) / BD;
    fast_on = (ht % 2) == 0;
    slow_on = ((ht / 2) % 2) == 0;
    blank   = (v == 0 && !fast_on) || (v > 0 && v < 200 && !slow_on);
    dig     = (v / pow10[idx]) % 10;
    e.k     = k;
    e.an    = blank ? 4'b1111 : (4'b1111 ^ (4'b0001 << idx));
    e.seg   = blank ? 7'h7F : seg_tab[dig];
    return e;
  endfunction

  task automatic push_range(int from, int to, int v);
    for (int k = from; k <= to; k++) sb_q.push_back(model(k, v));
  endtask

  // Present v right after the current edge and hold it for h cycles.
  task automatic drive(int v, int h);
    int c;
    c = cyc;
    Bin16 = v[15:0];
    push_range(vis(c), vis(c + h) - 1, clamp(v));
    repeat (h) @(posedge SYS_CLK);
    #1;
  endtask

  function automatic int rand_val();
    int v;
    case ($urandom_range(0, 4))
      0:       v = 0;
      1:       v = $urandom_range(1, 199);
      2:       v = $urandom_range(200, 9999);
      3:       v = $urandom_range(10000, 65535);
      default: begin
        case ($urandom_range(0, 3))
          0:       v = 199;
          1:       v = 200;
          2:       v = 9999;
          default: v = 10000;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic check_blank(string name);
    checks++;
    if (An !== 4'b1111 || Seg !== 7'h7F || Dp !== 1'b1) begin
      errors++;
      $display("FAIL %s: An=%b Seg=%h Dp=%b, required An=1111 Seg=7f Dp=1", name, An, Seg, Dp);
    end
  endtask

  always @(negedge SYS_CLK) begin
    if (running && RESET_N) begin
      while (sb_q.size() > 0 && sb_q[0].k < cyc) begin
        mon_e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed: expectation for cycle %0d not compared (now %0d)", mon_e.k, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].k == cyc) begin
        mon_e = sb_q.pop_front();
        checks++;
        if (An !== mon_e.an || Seg !== mon_e.seg || Dp !== 1'b1) begin
          errors++;
          $display("FAIL display k=%0d: An=%b Seg=%h Dp=%b, required An=%b Seg=%h Dp=1",
                   cyc, An, Seg, Dp, mon_e.an, mon_e.seg);
        end
      end
    end
  end

  initial begin
    int guard;
    RESET_N = 1'b0;
    Bin16   = 16'd0;
    #23;
    check_blank("reset_state");

    @(negedge SYS_CLK);
    RESET_N = 1'b1;
    running = 1'b1;
    push_range(1, vis(0) - 1, 0);

    drive(1234, 21);   // 1234 sampled on edge 19; 5678 arrives mid-SHIFT
    drive(5678, 300);
    drive(12000, 300);
    drive(205, 1000);
    drive(0, 450);
    drive(150, 450);
    drive(250, 100);
    for (int i = 0; i < 12; i++) drive(rand_val(), $urandom_range(5, 450));

    // Reset in the middle of a conversion
    guard = 0;
    while (((cyc - 1) % 18) != 5 && guard < 100) begin
      @(posedge SYS_CLK);
      #1;
      guard++;
    end
    #2;
    RESET_N = 1'b0;
    running = 1'b0;
    sb_q.delete();
    #1;
    check_blank("reset_mid_shift");
    @(negedge SYS_CLK);
    check_blank("reset_held");
    @(negedge SYS_CLK);
    RESET_N = 1'b1;
    running = 1'b1;
    push_range(1, vis(0) - 1, 0);
    drive(4321, 200);
    drive(199, 450);
    drive(200, 150);
    for (int i = 0; i < 6; i++) drive(rand_val(), $urandom_range(5, 300));

    guard = 0;
    while (sb_q.size() > 0 && guard < 3000) begin
      @(posedge SYS_CLK);
      guard++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    @(negedge SYS_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
